// File: rtl/pipe_fetch_decode_skid_if.sv
// Fetch->decode handshake bundle: upstream fetch signals, downstream decode signals and fill level.
// The stage uses the slave modport; whatever drives fetch and consumes decode uses master.
interface pipe_fetch_decode_skid_if #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] in_inst;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [1:0]            occupancy;

  modport master (
    output in_valid,
    output in_inst,
    output in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    input  in_pc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_inst,
    output out_pc,
    output occupancy
  );
endinterface

// File: rtl/pipe_fetch_decode_skid.sv
// Fetch->decode pipeline stage: main register drives decode, skid register absorbs one stall
// cycle so in_ready depends only on registered state.
module pipe_fetch_decode_skid #(
  parameter int unsigned          INST_WIDTH = 32,
  parameter int unsigned          PC_WIDTH   = 10,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_fetch_decode_skid_if.slave bus_io
);

  // Encoding equals the number of entries held, so it doubles as occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [INST_WIDTH-1:0] main_inst_q, main_inst_d;
  logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;

  logic in_ready, out_valid, in_fire, out_fire;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = bus_io.in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & bus_io.out_ready;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (flush) begin
      // A same-cycle out_fire has already been taken by decode; nothing left to keep.
      state_d     = StEmpty;
      main_inst_d = NOP_INST;
      main_pc_d   = '0;
      skid_inst_d = NOP_INST;
      skid_pc_d   = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_inst_d = bus_io.in_inst;
            main_pc_d   = bus_io.in_pc;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_inst_d = bus_io.in_inst;
            main_pc_d   = bus_io.in_pc;
          end else if (in_fire) begin
            skid_inst_d = bus_io.in_inst;
            skid_pc_d   = bus_io.in_pc;
            state_d     = StFull;
          end else if (out_fire) begin
            main_inst_d = NOP_INST;
            main_pc_d   = '0;
            state_d     = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_inst_d = skid_inst_q;
            main_pc_d   = skid_pc_q;
            skid_inst_d = NOP_INST;
            skid_pc_d   = '0;
            state_d     = StOne;
          end
        end
        default: begin
          state_d     = StEmpty;
          main_inst_d = NOP_INST;
          main_pc_d   = '0;
          skid_inst_d = NOP_INST;
          skid_pc_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      main_inst_q <= NOP_INST;
      main_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_inst  = main_inst_q;
  assign bus_io.out_pc    = main_pc_q;
  assign bus_io.occupancy = state_q;

endmodule

// File: tb/tb_pipe_fetch_decode_skid.sv
// Directed checks of the fetch->decode skid stage followed by a randomized scoreboard run.
module tb_pipe_fetch_decode_skid;

  localparam int unsigned IW = 32;
  localparam int unsigned PW = 10;

  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_errors;

  pipe_fetch_decode_skid_if #(.INST_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  pipe_fetch_decode_skid #(
    .INST_WIDTH(IW),
    .PC_WIDTH  (PW),
    .NOP_INST  ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus_io(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [PW-1:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_inst  = 32'hA000_0000 + 32'(pc);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_inst"}, bus.out_inst, 32'd0);
    check({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
    check({tag, "_occ"}, 32'(bus.occupancy), 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [PW-1:0] pc, input int occ);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
    check({tag, "_inst"}, bus.out_inst, 32'hA000_0000 + 32'(pc));
    check({tag, "_occ"}, 32'(bus.occupancy), 32'(occ));
  endtask

  logic [IW+PW-1:0] model_q[$];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // Reset, then release with no traffic.
    tick();
    tick();
    check_idle("rst");
    reset = 1'b1;
    tick();
    check_idle("rst_rel");

    // Streaming at full rate.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, PW'(i));
      tick();
      check_out("stream", PW'(i), 1);
    end
    offer(1'b0, '0);
    tick();
    check_idle("drain");

    // Back-pressure fills the skid; pc2 waits at the input.
    bus.out_ready = 1'b0;
    offer(1'b1, 10'd0);
    tick();
    offer(1'b1, 10'd1);
    tick();
    offer(1'b1, 10'd2);
    tick();
    check_out("full", 10'd0, 2);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check_out("stall_hold", 10'd0, 2);
    bus.out_ready = 1'b1;
    tick();
    check_out("skid_pop", 10'd1, 1);
    check("skid_pop_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("pc2_out", 10'd2, 1);
    offer(1'b0, '0);
    tick();
    check_idle("bp_drain");

    // Flush while full with a same-cycle offer.
    bus.out_ready = 1'b0;
    offer(1'b1, 10'd4);
    tick();
    offer(1'b1, 10'd5);
    tick();
    check("pre_flush_occ", 32'(bus.occupancy), 32'd2);
    offer(1'b1, 10'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, '0);
    check_idle("flush");
    tick();
    check_idle("flush_after");

    // Reset mid-transfer while full.
    offer(1'b1, 10'd8);
    tick();
    offer(1'b1, 10'd9);
    tick();
    offer(1'b0, '0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_idle("rst_full");
    bus.out_ready = 1'b0;
    tick();
    check_idle("rst_hold");
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    offer(1'b1, 10'd3);
    tick();
    check_out("post_rst", 10'd3, 1);
    offer(1'b0, '0);
    tick();
    check_idle("post_rst_drain");

    // Randomized traffic against a 2-deep FIFO reference.
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic v, r, f, in_f, out_f;
      logic [IW-1:0] inst;
      logic [PW-1:0] pc;
      if (model_q.size() > 0) begin
        check("rnd_valid", 32'(bus.out_valid), 32'd1);
        check("rnd_inst", bus.out_inst, model_q[0][IW+PW-1:PW]);
        check("rnd_pc", 32'(bus.out_pc), 32'(model_q[0][PW-1:0]));
      end else begin
        check("rnd_valid", 32'(bus.out_valid), 32'd0);
        check("rnd_inst", bus.out_inst, 32'd0);
        check("rnd_pc", 32'(bus.out_pc), 32'd0);
      end
      check("rnd_occ", 32'(bus.occupancy), 32'(model_q.size()));
      check("rnd_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));

      v    = ($urandom_range(0, 3) != 0);
      r    = $urandom_range(0, 1) == 1;
      f    = ($urandom_range(0, 31) == 0);
      inst = $urandom;
      pc   = PW'($urandom);
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.out_ready = r;
      flush         = f;

      in_f  = v && (model_q.size() < 2) && !f;
      out_f = (model_q.size() > 0) && r;
      if (f) begin
        model_q.delete();
      end else begin
        if (out_f) void'(model_q.pop_front());
        if (in_f) model_q.push_back({inst, pc});
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
